// File: rtl/bip_debug_sequencer.sv
// Sequencer between a host byte link, the BIP program-memory write port and the BIP core.
// Loads little-endian words, then free-runs or single-steps the core until HLT or abort.
module bip_debug_sequencer #(
    parameter int unsigned B  = 16,
    parameter int unsigned W  = 11,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic [B-1:0]  cpu_instr,
    output logic          pm_we,
    output logic [W-1:0]  pm_waddr,
    output logic [B-1:0]  pm_wdata,
    output logic          cpu_rst,
    output logic          cpu_en,
    output logic          halted,
    output logic          busy,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_HALTED
    } state_t;

    localparam logic [4:0] OP_HLT   = 5'b00000;
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_STOP = 8'h58;

    state_t        state_q;
    logic          pm_we_q;
    logic [W-1:0]  pm_waddr_q;
    logic [B-1:0]  pm_wdata_q;
    logic [7:0]    low_q;
    logic          phase_hi_q;
    logic          cpu_rst_q;
    logic          en_q;
    logic          halted_q;
    logic [CW-1:0] cycle_count_q;
    logic [CW-1:0] cycle_count_d;

    logic instr_hlt;
    logic word_hlt;
    logic load_done;
    logic unused_operand;

    // en_q is the registered enable request; the live HLT check masks it so the
    // HLT instruction presented this cycle is never executed.
    always_comb begin
        instr_hlt     = (cpu_instr[B-1 -: 5] == OP_HLT);
        word_hlt      = (pm_wdata_q[B-1 -: 5] == OP_HLT);
        load_done     = pm_we_q && (word_hlt || (pm_waddr_q == '1));
        cpu_en        = en_q && !instr_hlt;
        cycle_count_d = cycle_count_q;
        if (cpu_en && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CW'(1);
        end
    end

    assign unused_operand = ^cpu_instr[B-6:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pm_we_q       <= 1'b0;
            pm_waddr_q    <= '0;
            pm_wdata_q    <= '0;
            low_q         <= '0;
            phase_hi_q    <= 1'b0;
            cpu_rst_q     <= 1'b1;
            en_q          <= 1'b0;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            pm_we_q       <= 1'b0;
            cycle_count_q <= cycle_count_d;
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_LOAD: begin
                                state_q       <= ST_LOAD;
                                cpu_rst_q     <= 1'b1;
                                pm_waddr_q    <= '0;
                                cycle_count_q <= '0;
                                halted_q      <= 1'b0;
                                phase_hi_q    <= 1'b0;
                            end
                            CMD_RUN: begin
                                if (state_q == ST_IDLE) begin
                                    state_q <= ST_RUN;
                                    en_q    <= 1'b1;
                                end
                            end
                            CMD_STEP: begin
                                if (state_q == ST_IDLE) begin
                                    state_q <= ST_STEP;
                                    en_q    <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    // The address advances in the cycle after the write pulse.
                    if (pm_we_q) begin
                        pm_waddr_q <= pm_waddr_q + W'(1);
                    end
                    if (load_done) begin
                        state_q   <= ST_IDLE;
                        cpu_rst_q <= 1'b0;
                    end else if (rx_valid) begin
                        if (!phase_hi_q) begin
                            low_q      <= rx_data;
                            phase_hi_q <= 1'b1;
                        end else begin
                            pm_wdata_q <= B'({rx_data, low_q});
                            pm_we_q    <= 1'b1;
                            phase_hi_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (instr_hlt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                        en_q     <= 1'b0;
                    end else if (rx_valid && (rx_data == CMD_STOP)) begin
                        state_q <= ST_IDLE;
                        en_q    <= 1'b0;
                    end
                end
                ST_STEP: begin
                    en_q <= 1'b0;
                    if (instr_hlt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pm_we       = pm_we_q;
    assign pm_waddr    = pm_waddr_q;
    assign pm_wdata    = pm_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign halted      = halted_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// Scoreboard bench for bip_debug_sequencer: a default-width instance and a W=3 instance
// share all inputs; program-memory writes of both are checked against expected queues.
module tb_bip_debug_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] cpu_instr = 16'h1234;

    logic        pm_we, cpu_rst, cpu_en, halted, busy;
    logic [10:0] pm_waddr;
    logic [15:0] pm_wdata;
    logic [31:0] cycle_count;

    logic        pm_we3, cpu_rst3, cpu_en3, halted3, busy3;
    logic [2:0]  pm_waddr3;
    logic [15:0] pm_wdata3;
    logic [31:0] cycle_count3;

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    logic [26:0] qm[$];
    logic [18:0] q3[$];

    bip_debug_sequencer dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .cpu_instr(cpu_instr),
        .pm_we(pm_we), .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .cpu_rst(cpu_rst),
        .cpu_en(cpu_en), .halted(halted), .busy(busy), .cycle_count(cycle_count)
    );

    bip_debug_sequencer #(.W(3)) dut3 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .cpu_instr(cpu_instr),
        .pm_we(pm_we3), .pm_waddr(pm_waddr3), .pm_wdata(pm_wdata3), .cpu_rst(cpu_rst3),
        .cpu_en(cpu_en3), .halted(halted3), .busy(busy3), .cycle_count(cycle_count3)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [26:0] em;
        logic [18:0] e3;
        forever begin
            @(negedge clk);
            if (cpu_en === 1'b1) en_cnt++;
            if (pm_we === 1'b1) begin
                checks++;
                if (qm.size() == 0) begin
                    failures++;
                    $display("FAIL pm_write_main unexpected got=%h/%h", pm_waddr, pm_wdata);
                end else begin
                    em = qm.pop_front();
                    if ({pm_waddr, pm_wdata} !== em) begin
                        failures++;
                        $display("FAIL pm_write_main got=%h/%h exp=%h/%h", pm_waddr, pm_wdata, em[26:16], em[15:0]);
                    end
                end
            end
            if (pm_we3 === 1'b1) begin
                checks++;
                if (q3.size() == 0) begin
                    failures++;
                    $display("FAIL pm_write_w3 unexpected got=%h/%h", pm_waddr3, pm_wdata3);
                end else begin
                    e3 = q3.pop_front();
                    if ({pm_waddr3, pm_wdata3} !== e3) begin
                        failures++;
                        $display("FAIL pm_write_w3 got=%h/%h exp=%h/%h", pm_waddr3, pm_wdata3, e3[18:16], e3[15:0]);
                    end
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic load_word(input logic [15:0] w, input int addr);
        qm.push_back({11'(addr), w});
        q3.push_back({3'(addr), w});
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (pm_we !== 1'b0) begin failures++; $display("FAIL reset_pm_we got=%b exp=0", pm_we); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({pm_waddr, pm_wdata} !== 27'd0) begin failures++; $display("FAIL reset_pm got=%h/%h exp=0/0", pm_waddr, pm_wdata); end
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_load();
        send_byte(8'h4C);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
        load_word(16'h1234, 0);
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL load_cpu_rst_held got=%b exp=1", cpu_rst); end
        load_word(16'h0805, 1);
        load_word(16'h0000, 2);
        tick(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_exit_busy got=%b exp=0", busy); end
        checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL load_exit_cpu_rst got=%b exp=0", cpu_rst); end
        checks++; if (pm_waddr !== 11'd3) begin failures++; $display("FAIL load_exit_addr got=%0d exp=3", pm_waddr); end
        checks++; if (qm.size() !== 0) begin failures++; $display("FAIL load_pending got=%0d exp=0", qm.size()); end
    endtask

    task automatic test_run();
        int base;
        cpu_instr = 16'h1234;
        base = en_cnt;
        send_byte(8'h52);
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL run_first_en got=%b exp=1", cpu_en); end
        tick(6);
        tick(1);
        cpu_instr = 16'h0000;
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL run_hlt_en got=%b exp=0", cpu_en); end
        tick(1);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL run_halted got=%b exp=1", halted); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_halted_busy got=%b exp=0", busy); end
        checks++; if (cycle_count !== 32'd7) begin failures++; $display("FAIL run_count got=%0d exp=7", cycle_count); end
        checks++; if (en_cnt - base !== 7) begin failures++; $display("FAIL run_en_cycles got=%0d exp=7", en_cnt - base); end
        send_byte(8'h52);
        tick(2);
        checks++; if ({halted, busy} !== 2'b10) begin failures++; $display("FAIL run_refused got=%b%b exp=10", halted, busy); end
        checks++; if (cycle_count !== 32'd7) begin failures++; $display("FAIL run_refused_count got=%0d exp=7", cycle_count); end
    endtask

    task automatic test_step();
        int base;
        send_byte(8'h4C);
        load_word(16'h1111, 0);
        load_word(16'h0000, 1);
        tick(1);
        checks++; if ({halted, cycle_count} !== 33'd0) begin failures++; $display("FAIL step_load_clear got=%b/%0d exp=0/0", halted, cycle_count); end
        cpu_instr = 16'h4321;
        base = en_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h53);
            checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL step_pulse%0d got=%b exp=1", i, cpu_en); end
            tick(1);
            checks++; if ({cpu_en, busy} !== 2'b00) begin failures++; $display("FAIL step_after%0d got=%b%b exp=00", i, cpu_en, busy); end
        end
        checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL step_count got=%0d exp=3", cycle_count); end
        checks++; if (en_cnt - base !== 3) begin failures++; $display("FAIL step_en_cycles got=%0d exp=3", en_cnt - base); end
        cpu_instr = 16'h0000;
        send_byte(8'h53);
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_hlt_en got=%b exp=0", cpu_en); end
        tick(1);
        checks++; if ({halted, busy} !== 2'b10) begin failures++; $display("FAIL step_hlt_state got=%b%b exp=10", halted, busy); end
        cpu_instr = 16'h4321;
        send_byte(8'h53);
        checks++; if ({cpu_en, busy, halted} !== 3'b001) begin failures++; $display("FAIL step_refused got=%b%b%b exp=001", cpu_en, busy, halted); end
        checks++; if (en_cnt - base !== 3) begin failures++; $display("FAIL step_refused_cycles got=%0d exp=3", en_cnt - base); end
    endtask

    task automatic test_abort();
        int base;
        send_byte(8'h4C);
        load_word(16'h2222, 0);
        load_word(16'h0000, 1);
        tick(1);
        cpu_instr = 16'h1234;
        base = en_cnt;
        send_byte(8'h52);
        tick(3);
        send_byte(8'h58);
        checks++; if ({cpu_en, busy, halted} !== 3'b000) begin failures++; $display("FAIL abort_state got=%b%b%b exp=000", cpu_en, busy, halted); end
        checks++; if (cycle_count !== 32'd5) begin failures++; $display("FAIL abort_count got=%0d exp=5", cycle_count); end
        checks++; if (en_cnt - base !== 5) begin failures++; $display("FAIL abort_en_cycles got=%0d exp=5", en_cnt - base); end
        base = en_cnt;
        send_byte(8'h52);
        tick(2);
        @(posedge clk);
        #1;
        rx_data = 8'h58;
        rx_valid = 1'b1;
        cpu_instr = 16'h0000;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        checks++; if ({cpu_en, busy, halted} !== 3'b001) begin failures++; $display("FAIL prio_state got=%b%b%b exp=001", cpu_en, busy, halted); end
        checks++; if (cycle_count !== 32'd8) begin failures++; $display("FAIL prio_count got=%0d exp=8", cycle_count); end
        checks++; if (en_cnt - base !== 3) begin failures++; $display("FAIL prio_en_cycles got=%0d exp=3", en_cnt - base); end
    endtask

    task automatic test_reset_mid();
        cpu_instr = 16'h1234;
        send_byte(8'h4C);
        load_word(16'h3333, 0);
        load_word(16'h0000, 1);
        tick(1);
        send_byte(8'h52);
        tick(2);
        checks++; if ({cpu_en, cycle_count} !== {1'b1, 32'd2}) begin failures++; $display("FAIL midrun_pre got=%b/%0d exp=1/2", cpu_en, cycle_count); end
        #3 reset = 1'b1;
        #1;
        checks++; if ({cpu_en, cpu_rst, busy} !== 3'b010) begin failures++; $display("FAIL midrun_reset got=%b%b%b exp=010", cpu_en, cpu_rst, busy); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL midrun_reset_count got=%0d exp=0", cycle_count); end
        tick(1);
        reset = 1'b0;
        send_byte(8'h4C);
        send_byte(8'hAA);
        #3 reset = 1'b1;
        #1;
        checks++; if ({busy, pm_waddr} !== 12'd0) begin failures++; $display("FAIL midload_reset got=%b/%0d exp=0/0", busy, pm_waddr); end
        tick(1);
        reset = 1'b0;
        send_byte(8'h4C);
        load_word(16'hBEEF, 0);
        load_word(16'h0000, 1);
        tick(1);
        checks++; if ({busy, pm_waddr} !== {1'b0, 11'd2}) begin failures++; $display("FAIL midload_reload got=%b/%0d exp=0/2", busy, pm_waddr); end
    endtask

    task automatic test_wrap();
        send_byte(8'hFF);
        tick(1);
        checks++; if ({busy, halted, cpu_en} !== 3'b000) begin failures++; $display("FAIL idle_ff got=%b%b%b exp=000", busy, halted, cpu_en); end
        checks++; if ({busy3, halted3, cpu_en3} !== 3'b000) begin failures++; $display("FAIL idle_ff_w3 got=%b%b%b exp=000", busy3, halted3, cpu_en3); end
        send_byte(8'h4C);
        for (int i = 0; i < 8; i++) begin
            load_word(16'h0800 + 16'(i) * 16'h0101, i);
        end
        tick(1);
        checks++; if ({busy3, cpu_rst3, pm_waddr3} !== 5'b00000) begin failures++; $display("FAIL wrap_w3 got=%b%b/%0d exp=00/0", busy3, cpu_rst3, pm_waddr3); end
        checks++; if ({busy, cpu_rst, pm_waddr} !== {2'b11, 11'd8}) begin failures++; $display("FAIL wrap_main got=%b%b/%0d exp=11/8", busy, cpu_rst, pm_waddr); end
        checks++; if (qm.size() + q3.size() !== 0) begin failures++; $display("FAIL wrap_pending got=%0d exp=0", qm.size() + q3.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_load();
        test_run();
        test_step();
        test_abort();
        test_reset_mid();
        test_wrap();
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
